adder_perf_harness: RTL and testbench
=====================================

# adder_perf_harness

Parametrised successor to the registered adder performance wrapper. It registers operands through a configurable input pipeline into either the radix-4 online adder (`radix4adder_new`) or the conventional carry adder (`traditional_adder`). It adds an on-chip LFSR stimulus generator, a run-length controlled state machine, a valid pipeline and a MISR result signature. Silicon and FPGA timing and functional runs therefore need no external pattern source.

## Interface
Parameters:
- NO_OF_DIGITS, 8, operand digit count
- RADIX_BITS, 3, bits per digit field
- RADIX, 4, digit radix
- ONLINE_ADDER, 1, 1 = `radix4adder_new`, 0 = `traditional_adder`; instantiation and width mapping unchanged from the existing wrapper
- PIPE_STAGES, 1, operand register stages before the adder, legal 1..4
- W (local), NO_OF_DIGITS*RADIX_BITS

Ports:
- clk, in, 1, sole clock; all state updates on rising edge
- rst, in, 1, synchronous active-high reset
- start, in, 1, one-cycle pulse that begins a run
- mode, in, 1, 0 = external operands, 1 = LFSR operands; sampled on start
- run_len, in, 16, number of operands to issue; sampled on start
- seed, in, 32, LFSR seed; sampled on start
- input_1, in, W, external operand 1
- input_2, in, W, external operand 2
- cin, in, RADIX_BITS, external carry-in
- output_1_reg, out, W, registered adder result
- cout_reg, out, RADIX_BITS, registered carry-out
- busy, out, 1, high in RUN and DRAIN
- done, out, 1, high in DONE
- issued, out, 16, operands issued in the current or last run
- signature, out, 32, MISR value

## Operation
- States and transitions:
  - IDLE → RUN on start when run_len≠0.
  - IDLE → DONE on start when run_len=0; signature is 0.
  - RUN → DRAIN on the cycle issued reaches run_len.
  - DRAIN → DONE when the valid pipeline is empty.
  - DONE → RUN (or DONE when run_len=0) on start.
- start in RUN or DRAIN is ignored; mode, run_len and seed are not resampled.
- On an accepted start: issued←0, signature←0, LFSR←seed (seed=0 is replaced by 0x00000001).
- Issue:
  - In RUN, one operand triple enters stage 1 every cycle with valid=1, and issued increments.
  - In other states, stage 1 still loads the operand source but valid=0.
- Operand source:
  - mode 0: input_1, input_2, cin.
  - mode 1: LFSR, Galois, polynomial 0x80200003, advances once per issued operand.
    - input_1 = low W bits of the replicated LFSR.
    - input_2 = low W bits of the replicated bit-reversed LFSR.
    - cin = LFSR[RADIX_BITS-1:0].
- Digit sanitising (mode 1, ONLINE_ADDER=1 only): any RADIX_BITS field equal to the most-negative code (MSB=1, rest 0) is forced to 0, keeping digits in ±(RADIX-1).
- Compaction: when the valid bit aligned with output_1_reg is 1, signature ← MISR(signature, fold).
  - MISR polynomial is 0x00400007.
  - fold = XOR of 32-bit slices of {cout_reg, output_1_reg}, zero-padded at the top.
- output_1_reg and cout_reg update every cycle in every state, as in the existing wrapper.

## Timing
- Operand sampled at edge t appears on output_1_reg/cout_reg after edge t+PIPE_STAGES+1.
- The signature includes that result one edge later.
- DRAIN lasts PIPE_STAGES+2 cycles.
- done rises one cycle after the last compaction.
- Reset values:
  - output_1_reg, cout_reg, issued, signature, busy, done, all pipeline data and valid bits: 0.
  - State: IDLE. LFSR: 0x00000001.
- Reset mid-run aborts immediately with no partial done. A start asserted in the same cycle as rst is ignored.
- issued saturates at run_len. run_len=0xFFFF is legal.

## Structure
- Package `adder_perf_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - LFSR and MISR polynomial constants;
  - the fold function;
  - the digit-sanitise function.
- Sub-module `perf_misr` provides a 32-bit MISR with load-zero, enable and data inputs. It is reused by the planned multiplier harness.
- The adder is instantiated inside a generate on ONLINE_ADDER.

## Test plan
- Reset: hold rst 3 cycles → all outputs 0, busy=0, done=0.
- ONLINE_ADDER=0, PIPE_STAGES=2, mode 0, input_1=1, input_2=2, cin=0, start with run_len=1 → output_1_reg=3 after edge t+3; done 1+(PIPE_STAGES+2) cycles after start; issued=1.
- start with run_len=0 → DONE the next cycle, signature=0, issued=0.
- mode 1, seed=0x1234ABCD, run_len=1000, both ONLINE_ADDER values → signature equals the golden model; rerun with the same seed → identical signature.
- start pulsed mid-RUN and mid-DRAIN → ignored; run_len and signature unaffected.
- rst asserted 5 cycles into a run_len=100 run → IDLE next cycle, all outputs 0; a new start with seed=0 → LFSR uses 0x00000001 and the run completes.

Source files
------------

// File: rtl/adder_perf_pkg.sv
// adder_perf_pkg: shared types, polynomials and helper functions for the
// adder performance harness (and the planned multiplier harness).
//   state_e          : harness run-control states
//   LFSR_POLY        : Galois LFSR taps, right-shifting form
//   MISR_POLY        : MISR feedback taps, left-shifting form (x^32 implicit)
//   lfsr_step        : one LFSR advance
//   fold32           : XOR of all 32-bit slices of a zero-padded word
//   sanitise_digits  : clears digit fields holding the most-negative code
package adder_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY  = 32'h0040_0007;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

  // Widest {cout, result} word the helpers accept.
  localparam int FOLD_BITS = 256;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [31:0] fold32(input logic [FOLD_BITS-1:0] v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < FOLD_BITS / 32; k++) begin
      r ^= 32'(v >> (32 * k));
    end
    return r;
  endfunction

  // A field equal to 100..0 lies outside +/-(RADIX-1); only its MSB is set,
  // so clearing that bit turns it into digit 0.
  function automatic logic [FOLD_BITS-1:0] sanitise_digits(
    input logic [FOLD_BITS-1:0] v,
    input int unsigned          digit_bits,
    input int unsigned          n_digits
  );
    logic [FOLD_BITS-1:0] r, msb_mask, field_mask;
    r          = v;
    msb_mask   = FOLD_BITS'(1) << (digit_bits - 1);
    field_mask = (msb_mask << 1) - FOLD_BITS'(1);
    for (int unsigned i = 0; i < n_digits; i++) begin
      if (((v >> (i * digit_bits)) & field_mask) == msb_mask) begin
        r &= ~(msb_mask << (i * digit_bits));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/perf_misr.sv
// perf_misr: 32-bit multiple-input signature register.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (signature -> 0)
//   clr_i   : load zero (wins over en_i)
//   en_i    : compact data_i into the signature this cycle
//   data_i  : 32-bit word to compact
//   sig_o   : current signature
module perf_misr
  import adder_perf_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sig_o
);

  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/radix4adder_new.sv
// radix4adder_new: signed-digit (carry-free) adder. Each RADIX_BITS field is
// a two's-complement digit; cin is the transfer into digit 0 and cout the
// transfer out of the top digit.
//   input_1, input_2 : signed-digit operands
//   cin              : incoming transfer digit
//   output_1         : signed-digit sum
//   cout             : outgoing transfer digit (sign-extended)
module radix4adder_new #(
  parameter int NO_OF_DIGITS = 8,
  parameter int RADIX_BITS   = 3,
  parameter int RADIX        = 4
) (
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] input_1,
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] input_2,
  input  logic [RADIX_BITS-1:0]              cin,
  output logic [NO_OF_DIGITS*RADIX_BITS-1:0] output_1,
  output logic [RADIX_BITS-1:0]              cout
);

  localparam int EW = RADIX_BITS + 2;
  localparam logic signed [EW-1:0] HALF = EW'(RADIX / 2);
  localparam logic signed [EW-1:0] RAD  = EW'(RADIX);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

  logic signed [EW-1:0] a_d, b_d, p, t, w, t_in;

  // Per digit: p = a + b = RADIX*t + w with t in {-1,0,1}; the sum digit is
  // w plus the transfer from the digit below, so no carry ripples further.
  always_comb begin
    output_1 = '0;
    a_d      = '0;
    b_d      = '0;
    p        = '0;
    t        = '0;
    w        = '0;
    t_in     = {{2{cin[RADIX_BITS-1]}}, cin};
    for (int i = 0; i < NO_OF_DIGITS; i++) begin
      a_d = {{2{input_1[i*RADIX_BITS+RADIX_BITS-1]}}, input_1[i*RADIX_BITS +: RADIX_BITS]};
      b_d = {{2{input_2[i*RADIX_BITS+RADIX_BITS-1]}}, input_2[i*RADIX_BITS +: RADIX_BITS]};
      p   = a_d + b_d;
      if (p >= HALF)       t = ONE;
      else if (p < -HALF)  t = -ONE;
      else                 t = '0;
      if (t == ONE)        w = p - RAD;
      else if (t == -ONE)  w = p + RAD;
      else                 w = p;
      output_1[i*RADIX_BITS +: RADIX_BITS] = RADIX_BITS'(w + t_in);
      t_in = t;
    end
    cout = t_in[RADIX_BITS-1:0];
  end

endmodule

// File: rtl/traditional_adder.sv
// traditional_adder: binary carry adder.
//   input_1, input_2 : W-bit operands
//   cin              : carry-in, added as an unsigned value
//   output_1         : low W bits of the sum
//   cout             : carry out of bit W-1, zero-extended
module traditional_adder #(
  parameter int NO_OF_DIGITS = 8,
  parameter int RADIX_BITS   = 3
) (
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] input_1,
  input  logic [NO_OF_DIGITS*RADIX_BITS-1:0] input_2,
  input  logic [RADIX_BITS-1:0]              cin,
  output logic [NO_OF_DIGITS*RADIX_BITS-1:0] output_1,
  output logic [RADIX_BITS-1:0]              cout
);

  localparam int W = NO_OF_DIGITS * RADIX_BITS;

  logic [W:0] sum_full;

  assign sum_full = {1'b0, input_1} + {1'b0, input_2} + {{(W + 1 - RADIX_BITS){1'b0}}, cin};
  assign output_1 = sum_full[W-1:0];
  assign cout     = {{(RADIX_BITS - 1){1'b0}}, sum_full[W]};

endmodule

// File: rtl/adder_perf_harness.sv
// adder_perf_harness: self-stimulating performance wrapper around either the
// signed-digit online adder or the conventional carry adder.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : one-cycle run request (honoured in IDLE/DONE)
//   mode, run_len, seed    : run configuration, captured on an accepted start
//   input_1, input_2, cin  : external operands (mode 0)
//   output_1_reg, cout_reg : registered adder result / carry
//   busy, done             : RUN or DRAIN / DONE
//   issued                 : operands issued in the current or last run
//   signature              : MISR over every valid result
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | one operand issued per cycle until issued == run_len
// ST_DRAIN | no issue; waiting for the valid pipeline to empty
// ST_DONE  | signature final; a new start may begin another run
module adder_perf_harness
  import adder_perf_pkg::*;
#(
  parameter int NO_OF_DIGITS = 8,
  parameter int RADIX_BITS   = 3,
  parameter int RADIX        = 4,
  parameter int ONLINE_ADDER = 1,
  parameter int PIPE_STAGES  = 1,
  localparam int W = NO_OF_DIGITS * RADIX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [15:0]           run_len,
  input  logic [31:0]           seed,
  input  logic [W-1:0]          input_1,
  input  logic [W-1:0]          input_2,
  input  logic [RADIX_BITS-1:0] cin,
  output logic [W-1:0]          output_1_reg,
  output logic [RADIX_BITS-1:0] cout_reg,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           issued,
  output logic [31:0]           signature
);

  localparam int REPS = W / 32 + 1;

  state_e                state_q, state_d;
  logic                  mode_q;
  logic [15:0]           run_len_q, issued_q;
  logic [31:0]           lfsr_q, lfsr_rev;
  logic                  start_ok, issue, pipe_busy;
  logic [W-1:0]          src1, src2, sum_w;
  logic [RADIX_BITS-1:0] srcc, cout_w;

  logic [W-1:0]           opa_q [PIPE_STAGES];
  logic [W-1:0]           opb_q [PIPE_STAGES];
  logic [RADIX_BITS-1:0]  opc_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  logic                   out_vld_q;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign issue     = (state_q == ST_RUN);
  assign pipe_busy = (|vld_q) || out_vld_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (run_len == 16'd0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (issued_q + 16'd1 == run_len_q) state_d = ST_DRAIN;
      ST_DRAIN:         if (!pipe_busy) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      run_len_q <= '0;
      issued_q  <= '0;
      lfsr_q    <= LFSR_RESET;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q    <= mode;
        run_len_q <= run_len;
        issued_q  <= '0;
        lfsr_q    <= (seed == 32'h0) ? LFSR_RESET : seed;
      end else if (issue) begin
        if (issued_q != run_len_q) issued_q <= issued_q + 16'd1;
        lfsr_q <= lfsr_step(lfsr_q);
      end
    end
  end

  assign lfsr_rev = {<<{lfsr_q}};

  // Operands wider than 32 bits see the LFSR word repeated.
  always_comb begin
    if (mode_q) begin
      src1 = W'({REPS{lfsr_q}});
      src2 = W'({REPS{lfsr_rev}});
      srcc = lfsr_q[RADIX_BITS-1:0];
      if (ONLINE_ADDER != 0) begin
        src1 = W'(sanitise_digits(FOLD_BITS'(src1), RADIX_BITS, NO_OF_DIGITS));
        src2 = W'(sanitise_digits(FOLD_BITS'(src2), RADIX_BITS, NO_OF_DIGITS));
        srcc = RADIX_BITS'(sanitise_digits(FOLD_BITS'(srcc), RADIX_BITS, 1));
      end
    end else begin
      src1 = input_1;
      src2 = input_2;
      srcc = cin;
    end
  end

  // Stage 0 loads every cycle; only the valid bit depends on the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        opc_q[k] <= '0;
      end
      vld_q        <= '0;
      out_vld_q    <= 1'b0;
      output_1_reg <= '0;
      cout_reg     <= '0;
    end else begin
      opa_q[0] <= src1;
      opb_q[0] <= src2;
      opc_q[0] <= srcc;
      vld_q[0] <= issue;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        opa_q[k] <= opa_q[k-1];
        opb_q[k] <= opb_q[k-1];
        opc_q[k] <= opc_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
      output_1_reg <= sum_w;
      cout_reg     <= cout_w;
      out_vld_q    <= vld_q[PIPE_STAGES-1];
    end
  end

  if (ONLINE_ADDER != 0) begin : g_online
    radix4adder_new #(
      .NO_OF_DIGITS(NO_OF_DIGITS),
      .RADIX_BITS  (RADIX_BITS),
      .RADIX       (RADIX)
    ) u_adder (
      .input_1 (opa_q[PIPE_STAGES-1]),
      .input_2 (opb_q[PIPE_STAGES-1]),
      .cin     (opc_q[PIPE_STAGES-1]),
      .output_1(sum_w),
      .cout    (cout_w)
    );
  end else begin : g_trad
    traditional_adder #(
      .NO_OF_DIGITS(NO_OF_DIGITS),
      .RADIX_BITS  (RADIX_BITS)
    ) u_adder (
      .input_1 (opa_q[PIPE_STAGES-1]),
      .input_2 (opb_q[PIPE_STAGES-1]),
      .cin     (opc_q[PIPE_STAGES-1]),
      .output_1(sum_w),
      .cout    (cout_w)
    );
  end

  perf_misr u_misr (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start_ok),
    .en_i  (out_vld_q),
    .data_i(fold32(FOLD_BITS'({cout_reg, output_1_reg}))),
    .sig_o (signature)
  );

  assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done   = (state_q == ST_DONE);
  assign issued = issued_q;

endmodule

// File: tb/tb_adder_perf_harness.sv
module tb_adder_perf_harness;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, start, mode;
  logic [15:0]  run_len;
  logic [31:0]  seed;
  logic [W-1:0] input_1, input_2;
  logic [2:0]   cin;

  logic [W-1:0] out0, out1;
  logic [2:0]   cout0, cout1;
  logic         busy0, busy1, done0, done1;
  logic [15:0]  issued0, issued1;
  logic [31:0]  sig0, sig1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_perf_harness #(.ONLINE_ADDER(0), .PIPE_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .run_len(run_len), .seed(seed),
    .input_1(input_1), .input_2(input_2), .cin(cin),
    .output_1_reg(out0), .cout_reg(cout0), .busy(busy0), .done(done0),
    .issued(issued0), .signature(sig0)
  );

  adder_perf_harness #(.ONLINE_ADDER(1), .PIPE_STAGES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .run_len(run_len), .seed(seed),
    .input_1(input_1), .input_2(input_2), .cin(cin),
    .output_1_reg(out1), .cout_reg(cout1), .busy(busy1), .done(done1),
    .issued(issued1), .signature(sig1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic m, input logic [15:0] len, input logic [31:0] s);
    mode    = m;
    run_len = len;
    seed    = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(done0 && done1) && n < budget) begin
      tick();
      n++;
    end
    check_eq("done0_reached", 32'(done0), 32'd1);
    check_eq("done1_reached", 32'(done1), 32'd1);
  endtask

  // Reference models.
  function automatic logic [26:0] add_trad(input logic [23:0] a, input logic [23:0] b,
                                           input logic [2:0] c);
    logic [24:0] s;
    s = {1'b0, a} + {1'b0, b} + {22'd0, c};
    return {2'b00, s};
  endfunction

  function automatic logic [26:0] add_online(input logic [23:0] a, input logic [23:0] b,
                                             input logic [2:0] c);
    logic [23:0] s;
    logic [31:0] tmp;
    int ai, bi, p, t, w, tin;
    tin = $signed(c);
    for (int i = 0; i < 8; i++) begin
      ai = $signed(a[3*i +: 3]);
      bi = $signed(b[3*i +: 3]);
      p  = ai + bi;
      if (p >= 2)       t = 1;
      else if (p <= -3) t = -1;
      else              t = 0;
      w   = p - 4 * t;
      tmp = w + tin;
      s[3*i +: 3] = tmp[2:0];
      tin = t;
    end
    tmp = tin;
    return {tmp[2:0], s};
  endfunction

  function automatic logic [23:0] clean(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 8; i++) if (r[3*i +: 3] == 3'b100) r[3*i +: 3] = 3'b000;
    return r;
  endfunction

  function automatic logic [31:0] golden(input bit online, input logic [31:0] s0, input int n);
    logic [31:0] l, sig, rev;
    logic [23:0] a, b;
    logic [2:0]  c;
    logic [26:0] r;
    l   = (s0 == 32'h0) ? 32'h1 : s0;
    sig = 32'h0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 32; i++) rev[i] = l[31-i];
      a = l[23:0];
      b = rev[23:0];
      c = l[2:0];
      if (online) begin
        a = clean(a);
        b = clean(b);
        if (c == 3'b100) c = 3'b000;
        r = add_online(a, b, c);
      end else begin
        r = add_trad(a, b, c);
      end
      sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h0040_0007 : 32'h0) ^ {5'd0, r};
      l   = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    end
    return sig;
  endfunction

  task automatic check_run(input string tag, input logic [31:0] s0, input int n);
    check_eq({tag, "_sig0"},    sig0, golden(1'b0, s0, n));
    check_eq({tag, "_sig1"},    sig1, golden(1'b1, s0, n));
    check_eq({tag, "_issued0"}, 32'(issued0), 32'(n));
    check_eq({tag, "_issued1"}, 32'(issued1), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; run_len = '0; seed = '0;
    input_1 = '0; input_2 = '0; cin = '0;
    repeat (3) tick();

    check_eq("rst_out0",    32'(out0),    32'h0);
    check_eq("rst_cout0",   32'(cout0),   32'h0);
    check_eq("rst_busy0",   32'(busy0),   32'h0);
    check_eq("rst_done0",   32'(done0),   32'h0);
    check_eq("rst_issued0", 32'(issued0), 32'h0);
    check_eq("rst_sig0",    sig0,         32'h0);
    check_eq("rst_out1",    32'(out1),    32'h0);
    check_eq("rst_sig1",    sig1,         32'h0);
    rst = 1'b0;

    // Single external operand 1+2: latency and drain timing.
    pulse_start(1'b0, 16'd1, 32'h0);          // now just after start edge s
    input_1 = 24'd1; input_2 = 24'd2; cin = 3'd0;
    check_eq("one_busy", 32'(busy0), 32'd1);
    tick();                                    // s+1: operand issued
    input_1 = '0; input_2 = '0;
    check_eq("one_issued", 32'(issued0), 32'd1);
    tick();                                    // s+2
    check_eq("lat_early0", 32'(out0), 32'h0);
    tick();                                    // s+3
    check_eq("lat_out0",   32'(out0),  32'd3);
    check_eq("lat_cout0",  32'(cout0), 32'd0);
    check_eq("lat_early1", 32'(out1),  32'h0);
    tick();                                    // s+4
    check_eq("lat_after0", 32'(out0),  32'h0);
    check_eq("lat_out1",   32'(out1),  32'h00000F);
    check_eq("done0_early", 32'(done0), 32'd0);
    tick();                                    // s+5
    check_eq("done0_on_time", 32'(done0), 32'd1);
    check_eq("busy0_off",     32'(busy0), 32'd0);
    check_eq("one_sig0",      sig0,       32'd3);
    tick();                                    // s+6
    check_eq("done1_on_time", 32'(done1), 32'd1);
    check_eq("one_sig1",      sig1,       32'h0000000F);

    // Zero-length run.
    pulse_start(1'b0, 16'd0, 32'h0);
    check_eq("zero_done0",   32'(done0),   32'd1);
    check_eq("zero_busy0",   32'(busy0),   32'd0);
    check_eq("zero_sig0",    sig0,         32'h0);
    check_eq("zero_issued0", 32'(issued0), 32'h0);
    check_eq("zero_sig1",    sig1,         32'h0);

    // LFSR runs, repeated with the same seed.
    for (int r = 0; r < 2; r++) begin
      pulse_start(1'b1, 16'd1000, 32'h1234_ABCD);
      wait_done(1200);
      check_run((r == 0) ? "lfsr_a" : "lfsr_b", 32'h1234_ABCD, 1000);
    end

    // start pulses during RUN and during DRAIN are ignored.
    pulse_start(1'b1, 16'd50, 32'hCAFE_F00D);
    repeat (10) tick();
    pulse_start(1'b0, 16'd7, 32'h1);
    check_eq("midrun_busy", 32'(busy0), 32'd1);
    n = 0;
    while (issued0 != 16'd50 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_reached", 32'(issued0), 32'd50);
    pulse_start(1'b0, 16'd3, 32'h2);
    check_eq("middrain_busy", 32'(busy0), 32'd1);
    wait_done(100);
    check_run("ignore", 32'hCAFE_F00D, 50);

    // Reset mid-run, start held with reset, then seed 0.
    pulse_start(1'b1, 16'd100, 32'h0000_0055);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_eq("abort_busy0",   32'(busy0),   32'd0);
    check_eq("abort_done0",   32'(done0),   32'd0);
    check_eq("abort_issued0", 32'(issued0), 32'd0);
    check_eq("abort_sig0",    sig0,         32'h0);
    check_eq("abort_out0",    32'(out0),    32'h0);
    check_eq("abort_out1",    32'(out1),    32'h0);
    check_eq("abort_busy1",   32'(busy1),   32'd0);
    start = 1'b1; run_len = 16'd5;
    tick();
    start = 1'b0; rst = 1'b0;
    tick();
    check_eq("rst_start_busy0", 32'(busy0), 32'd0);
    check_eq("rst_start_done0", 32'(done0), 32'd0);
    pulse_start(1'b1, 16'd20, 32'h0);
    wait_done(100);
    check_run("seed0", 32'h0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
